wb_arbiter_2m: RTL
==================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter that shares the 64-bit memory harness between two requesters (e.g. CPU bridge and DMA/testbench injector).
- Grant is round-robin and locked for the whole bus cycle (while the granted master's cyc is high).
- The granted master's request is muxed to the slave; ack and read data are routed back to it only.
- Sits directly between the masters and the memory slave in the simulation/system top.

Parameters:
- addr_width, 64, address bus width
- data_width, 64, data bus width
- sel_width, 8, byte-select width (data_width/8)
- timeout_cycles, 255, cycles without ack before abort (only used with macro)

Ports:
- sys_clock_i  in  1  system clock, all state on rising edge
- sys_reset_i  in  1  asynchronous, active-low reset
- wbm0_cycle_i, wbm0_strobe_i, wbm0_we_i  in  1 each  master 0 control
- wbm0_addr_i  in  addr_width  master 0 address
- wbm0_data_i  in  data_width  master 0 write data
- wbm0_sel_i  in  sel_width  master 0 byte select
- wbm0_data_o  out  data_width  read data to master 0
- wbm0_ack_o  out  1  ack to master 0
- wbm0_err_o  out  1  error to master 0
- wbm1_*  same set as wbm0_*, for master 1
- wbs_cycle_o, wbs_strobe_o, wbs_we_o  out  1 each  slave control
- wbs_addr_o  out  addr_width  slave address
- wbs_data_o  out  data_width  slave write data
- wbs_sel_o  out  sel_width  slave byte select
- wbs_data_i  in  data_width  slave read data
- wbs_ack_i  in  1  slave ack
- arb_grant_o  out  2  one-hot current grant; 00 = none

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT (ABORT is used only with the macro).
- Reset (sys_reset_i=0, async): state=IDLE, priority pointer=master 0, arb_grant_o=00, all wbs_* outputs 0, all wbm*_ack_o/err_o 0, wbm*_data_o 0.
- IDLE arbitration:
  - Request = cycle_i & strobe_i.
  - Only one requester: grant it.
  - Both requesting: grant the master the pointer favours.
  - Grant is registered: one cycle of arbitration latency from request to wbs_cycle_o.
- GNTn:
  - wbs_* outputs are a combinational copy of master n's inputs.
  - wbmn_ack_o = wbs_ack_i and wbmn_data_o = wbs_data_i.
  - The other master sees ack=0, err=0, data=0.
  - arb_grant_o is one-hot n.
  - The pointer updates to favour the other master when the grant is issued.
- Release: when master n drops cycle_i, the state moves on the next edge.
  - If the other master is requesting, go directly to its GNT state (no IDLE bubble).
  - Otherwise go to IDLE.
  - An ack arriving in the release cycle is still routed to n.
- Grant never changes while the granted master's cycle_i is high, including stb-low gaps inside a block transfer.
- Cycle and strobe in IDLE/ABORT: wbs_cycle_o=wbs_strobe_o=0, wbs_addr_o/wbs_data_o/wbs_sel_o=0, wbs_we_o=0.
- Simultaneous reset and request: reset wins.
- Reset mid-transfer aborts the transfer silently, with no ack and no err.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter clears on grant and on every wbs_ack_i.
  - It increments each cycle in GNTn with wbs_strobe_o=1 and wbs_ack_i=0.
  - When the count reaches timeout_cycles: pulse wbmn_err_o for one cycle, enter ABORT, and drive slave cyc/stb low.
  - ABORT returns to IDLE (or the other GNT) when master n drops cycle_i.
- Without the macro: no counter, no ABORT state, and both err outputs are tied to 0.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2, ABORT=2'd3)
  - grant one-hot constants
  - the default timeout value
- One sub-module, wb_arb_timeout: the counter and compare, instantiated only under WB_ARBITER_TIMEOUT_EN.

Test Plan:
- Single master read: m0 requests read at addr 0x80 with slave returning 0x02468ACE13579BDF → wbs_cycle_o rises 1 cycle later, m0 gets ack and that data, m1 ack stays 0, arb_grant_o=01.
- Simultaneous request after reset: both masters raise cyc/stb on the same edge → m0 granted first (arb_grant_o=01); on m0 cyc drop, m1 is granted the next cycle with no IDLE cycle (arb_grant_o=10).
- Round-robin fairness: both masters request continuously with 1-beat cycles for 8 transfers → grants alternate 01,10,01,10…; each master gets exactly 4.
- Lock with byte-select write: m1 performs a 4-beat burst with sel=0x0F while m0 requests mid-burst → wbs_sel_o=0x0F throughout, grant stays 10 until m1 drops cyc, then m0 is granted.
- Reset mid-transfer: assert sys_reset_i=0 during GNT0 → all outputs 0 asynchronously; after release, m1 requesting alone is granted.
- Timeout (macro on, timeout_cycles=4): slave never acks → wbm0_err_o pulses exactly 4 cycles after strobe, wbs_cycle_o drops, and the arbiter returns to IDLE when m0 drops cyc. With the macro off, err stays 0 and the grant is held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: FSM state encoding,
// one-hot grant values and the default abort timeout.
package wb_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall counter for the arbiter: counts strobe cycles without an ack and
// flags expiry when the count reaches timeout_cycles. Only exists when
// WB_ARBITER_TIMEOUT_EN is defined, since the arbiter instantiates it only then.
`ifdef WB_ARBITER_TIMEOUT_EN
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int timeout_cycles = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int cnt_width = (timeout_cycles > 255) ? 16 : 8;

    logic [cnt_width-1:0] count;

    assign expired = (count == cnt_width'(timeout_cycles));

    // Saturating up-count of stalled strobe cycles; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter with round-robin grant locked for
// the whole bus cycle. Optional stall timeout with abort is enabled by the
// WB_ARBITER_TIMEOUT_EN macro; without it err outputs are tied low.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner, arbitrating between cyc&stb requests
//   ST_GNT0  | master 0 owns the slave until it drops cyc
//   ST_GNT1  | master 1 owns the slave until it drops cyc
//   ST_ABORT | timed-out owner cut off from slave, waiting for its cyc to drop
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int addr_width     = 64,
    parameter int data_width     = 64,
    parameter int sel_width      = 8,
    parameter int timeout_cycles = DEFAULT_TIMEOUT
) (
    input  logic                  sys_clock_i,
    input  logic                  sys_reset_i,

    input  logic                  wbm0_cycle_i,
    input  logic                  wbm0_strobe_i,
    input  logic                  wbm0_we_i,
    input  logic [addr_width-1:0] wbm0_addr_i,
    input  logic [data_width-1:0] wbm0_data_i,
    input  logic [sel_width-1:0]  wbm0_sel_i,
    output logic [data_width-1:0] wbm0_data_o,
    output logic                  wbm0_ack_o,
    output logic                  wbm0_err_o,

    input  logic                  wbm1_cycle_i,
    input  logic                  wbm1_strobe_i,
    input  logic                  wbm1_we_i,
    input  logic [addr_width-1:0] wbm1_addr_i,
    input  logic [data_width-1:0] wbm1_data_i,
    input  logic [sel_width-1:0]  wbm1_sel_i,
    output logic [data_width-1:0] wbm1_data_o,
    output logic                  wbm1_ack_o,
    output logic                  wbm1_err_o,

    output logic                  wbs_cycle_o,
    output logic                  wbs_strobe_o,
    output logic                  wbs_we_o,
    output logic [addr_width-1:0] wbs_addr_o,
    output logic [data_width-1:0] wbs_data_o,
    output logic [sel_width-1:0]  wbs_sel_o,
    input  logic [data_width-1:0] wbs_data_i,
    input  logic                  wbs_ack_i,

    output logic [1:0]            arb_grant_o
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       favour_m1;
    logic       req0;
    logic       req1;

    assign req0 = wbm0_cycle_i & wbm0_strobe_i;
    assign req1 = wbm1_cycle_i & wbm1_strobe_i;

`ifdef WB_ARBITER_TIMEOUT_EN
    logic expired;
    logic timeout_hit;
    logic in_gnt;
    logic grant_start;
    logic cnt_clear;
    logic cnt_en;
    logic abort_owner;

    assign in_gnt      = (state == ST_GNT0) | (state == ST_GNT1);
    assign grant_start = (state_next != state) &
                         ((state_next == ST_GNT0) | (state_next == ST_GNT1));
    // Held clear outside a grant so a direct hand-over starts from zero too.
    assign cnt_clear   = ~in_gnt | wbs_ack_i | grant_start;
    assign cnt_en      = in_gnt & wbs_strobe_o & ~wbs_ack_i;
    // A late ack in the expiry cycle wins, so ack and err never coincide.
    assign timeout_hit = expired & ~wbs_ack_i;

    wb_arb_timeout #(
        .timeout_cycles(timeout_cycles)
    ) u_timeout (
        .clk      (sys_clock_i),
        .rst_n    (sys_reset_i),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .expired  (expired)
    );

    // Remember which master was last granted so ABORT knows whose cyc to watch.
    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            abort_owner <= 1'b0;
        end else if (state == ST_GNT0) begin
            abort_owner <= 1'b0;
        end else if (state == ST_GNT1) begin
            abort_owner <= 1'b1;
        end
    end

    assign wbm0_err_o = (state == ST_GNT0) & timeout_hit;
    assign wbm1_err_o = (state == ST_GNT1) & timeout_hit;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = timeout_cycles;
    assign wbm0_err_o     = 1'b0;
    assign wbm1_err_o     = 1'b0;
`endif

    // Next-state: arbitrate in IDLE, hold the grant while the owner's cyc is high.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req0 && (!req1 || !favour_m1)) begin
                    state_next = ST_GNT0;
                end else if (req1) begin
                    state_next = ST_GNT1;
                end
            end
            ST_GNT0: begin
`ifdef WB_ARBITER_TIMEOUT_EN
                if (timeout_hit) begin
                    state_next = ST_ABORT;
                end else
`endif
                if (!wbm0_cycle_i) begin
                    state_next = req1 ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
`ifdef WB_ARBITER_TIMEOUT_EN
                if (timeout_hit) begin
                    state_next = ST_ABORT;
                end else
`endif
                if (!wbm1_cycle_i) begin
                    state_next = req0 ? ST_GNT0 : ST_IDLE;
                end
            end
            ST_ABORT: begin
`ifdef WB_ARBITER_TIMEOUT_EN
                if (!abort_owner && !wbm0_cycle_i) begin
                    state_next = req1 ? ST_GNT1 : ST_IDLE;
                end else if (abort_owner && !wbm1_cycle_i) begin
                    state_next = req0 ? ST_GNT0 : ST_IDLE;
                end
`else
                // Unreachable without the timeout; recover to IDLE.
                state_next = ST_IDLE;
`endif
            end
        endcase
    end

    // State register; the pointer flips to favour the other master on each new grant.
    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            state     <= ST_IDLE;
            favour_m1 <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == ST_GNT0 && state != ST_GNT0) begin
                favour_m1 <= 1'b1;
            end else if (state_next == ST_GNT1 && state != ST_GNT1) begin
                favour_m1 <= 1'b0;
            end
        end
    end

    // Request/response mux: owner's signals pass straight through, everyone else sees zeros.
    always_comb begin
        wbs_cycle_o  = 1'b0;
        wbs_strobe_o = 1'b0;
        wbs_we_o     = 1'b0;
        wbs_addr_o   = '0;
        wbs_data_o   = '0;
        wbs_sel_o    = '0;
        wbm0_ack_o   = 1'b0;
        wbm0_data_o  = '0;
        wbm1_ack_o   = 1'b0;
        wbm1_data_o  = '0;
        arb_grant_o  = GRANT_NONE;
        case (state)
            ST_GNT0: begin
                wbs_cycle_o  = wbm0_cycle_i;
                wbs_strobe_o = wbm0_strobe_i;
                wbs_we_o     = wbm0_we_i;
                wbs_addr_o   = wbm0_addr_i;
                wbs_data_o   = wbm0_data_i;
                wbs_sel_o    = wbm0_sel_i;
                wbm0_ack_o   = wbs_ack_i;
                wbm0_data_o  = wbs_data_i;
                arb_grant_o  = GRANT_M0;
            end
            ST_GNT1: begin
                wbs_cycle_o  = wbm1_cycle_i;
                wbs_strobe_o = wbm1_strobe_i;
                wbs_we_o     = wbm1_we_i;
                wbs_addr_o   = wbm1_addr_i;
                wbs_data_o   = wbm1_data_i;
                wbs_sel_o    = wbm1_sel_i;
                wbm1_ack_o   = wbs_ack_i;
                wbm1_data_o  = wbs_data_i;
                arb_grant_o  = GRANT_M1;
            end
            default: begin
            end
        endcase
    end

endmodule
